// File: rtl/branch_predictor.sv
// Dynamic branch predictor with branch target buffer.
// IF stage: combinational lookup of the fetch PC returns a predicted next PC.
// EX stage: combinational resolve raises a redirect on a wrong prediction;
// the direct-mapped table of 2-bit saturating counters trains on the edge.
// Saturating statistics count resolved branches and mispredict cycles.
module branch_predictor #(
  parameter int INDEX_BITS = 4,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      if_pc,
  output logic             pred_taken,
  output logic [31:0]      pred_target,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic             ex_uncond,
  input  logic [31:0]      ex_pc,
  input  logic             ex_taken,
  input  logic [31:0]      ex_target,
  input  logic             ex_pred_taken,
  input  logic [31:0]      ex_pred_target,
  output logic             mispredict,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_mispredicts
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = 32 - INDEX_BITS - 2;

  // Read-side view of the table, one element per entry.
  logic [ENTRIES-1:0] valid_vec;
  logic [TAG_W-1:0]   tag_vec    [ENTRIES];
  logic [31:0]        target_vec [ENTRIES];
  logic [1:0]         ctr_vec    [ENTRIES];

  logic [INDEX_BITS-1:0] if_idx;
  logic [TAG_W-1:0]      if_tag;
  logic                  if_hit;
  logic [INDEX_BITS-1:0] ex_idx;
  logic [TAG_W-1:0]      ex_tag;
  logic                  ex_hit;
  logic                  ex_br;
  logic                  ex_alias;

  logic [CNT_W-1:0] stat_branches_reg;
  logic [CNT_W-1:0] stat_mispredicts_reg;

  // Byte-offset bits of the word-aligned PCs are never used.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};

  assign if_idx = if_pc[INDEX_BITS+1:2];
  assign if_tag = if_pc[31:INDEX_BITS+2];
  assign ex_idx = ex_pc[INDEX_BITS+1:2];
  assign ex_tag = ex_pc[31:INDEX_BITS+2];

  assign if_hit   = valid_vec[if_idx] && (tag_vec[if_idx] == if_tag);
  assign ex_hit   = valid_vec[ex_idx] && (tag_vec[ex_idx] == ex_tag);
  assign ex_br    = ex_valid && ex_is_branch;
  assign ex_alias = ex_valid && !ex_is_branch && ex_pred_taken;

  // Lookup: predict taken only on a hit with a strongly/weakly taken counter.
  always_comb begin
    pred_taken  = if_hit && ctr_vec[if_idx][1];
    pred_target = if_pc + 32'd4;
    if (pred_taken) begin
      pred_target = target_vec[if_idx];
    end
  end

  // Resolve: compare the real outcome with what the front end assumed.
  always_comb begin
    mispredict  = 1'b0;
    redirect_pc = ex_pc + 32'd4;
    if (ex_br) begin
      mispredict = (ex_taken != ex_pred_taken) ||
                   (ex_taken && (ex_target != ex_pred_target));
      if (ex_taken) begin
        redirect_pc = ex_target;
      end
    end else if (ex_alias) begin
      mispredict = 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
      localparam logic [INDEX_BITS-1:0] MY_IDX = INDEX_BITS'(gi);

      logic             valid_reg;
      logic [TAG_W-1:0] tag_reg;
      logic [31:0]      target_reg;
      logic [1:0]       ctr_reg;

      assign valid_vec[gi]  = valid_reg;
      assign tag_vec[gi]    = tag_reg;
      assign target_vec[gi] = target_reg;
      assign ctr_vec[gi]    = ctr_reg;

      // Train this entry when the EX instruction maps onto it.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_reg  <= 1'b0;
          tag_reg    <= '0;
          target_reg <= '0;
          ctr_reg    <= 2'd1;
        end else if (ex_idx == MY_IDX) begin
          if (ex_br) begin
            if (ex_hit) begin
              if (ex_taken) begin
                target_reg <= ex_target;
                if (ctr_reg != 2'd3) ctr_reg <= ctr_reg + 2'd1;
              end else if (ctr_reg != 2'd0) begin
                ctr_reg <= ctr_reg - 2'd1;
              end
              // Jumps are always taken, so pin them at strongly taken.
              if (ex_uncond) ctr_reg <= 2'd3;
            end else if (ex_taken) begin
              valid_reg  <= 1'b1;
              tag_reg    <= ex_tag;
              target_reg <= ex_target;
              ctr_reg    <= ex_uncond ? 2'd3 : 2'd2;
            end
          end else if (ex_alias && ex_hit) begin
            // A non-branch matched this entry: drop it so it stops aliasing.
            valid_reg <= 1'b0;
          end
        end
      end
    end
  endgenerate

  // Statistics counters, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches_reg    <= '0;
      stat_mispredicts_reg <= '0;
    end else begin
      if (ex_br && (stat_branches_reg != {CNT_W{1'b1}})) begin
        stat_branches_reg <= stat_branches_reg + 1'b1;
      end
      if (mispredict && (stat_mispredicts_reg != {CNT_W{1'b1}})) begin
        stat_mispredicts_reg <= stat_mispredicts_reg + 1'b1;
      end
    end
  end

  assign stat_branches    = stat_branches_reg;
  assign stat_mispredicts = stat_mispredicts_reg;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed table-driven bench for branch_predictor, plus hand-written
// sequences for asynchronous reset and statistics saturation.
module tb_branch_predictor;

  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic [31:0]   if_pc;
  logic          pred_taken;
  logic [31:0]   pred_target;
  logic          ex_valid;
  logic          ex_is_branch;
  logic          ex_uncond;
  logic [31:0]   ex_pc;
  logic          ex_taken;
  logic [31:0]   ex_target;
  logic          ex_pred_taken;
  logic [31:0]   ex_pred_target;
  logic          mispredict;
  logic [31:0]   redirect_pc;
  logic [CW-1:0] stat_branches;
  logic [CW-1:0] stat_mispredicts;

  int n_checks = 0;
  int n_fail   = 0;

  branch_predictor #(.INDEX_BITS(4), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_uncond(ex_uncond),
    .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] if_pc;
    logic        v, br, unc;
    logic [31:0] pc;
    logic        tk;
    logic [31:0] tgt;
    logic        ptk;
    logic [31:0] ptgt;
    logic        e_pt;
    logic [31:0] e_ptgt;
    logic        e_mis;
    logic [31:0] e_red;
  } vec_t;

  vec_t vecs [25];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t x);
    if_pc = x.if_pc; ex_valid = x.v; ex_is_branch = x.br; ex_uncond = x.unc;
    ex_pc = x.pc; ex_taken = x.tk; ex_target = x.tgt;
    ex_pred_taken = x.ptk; ex_pred_target = x.ptgt;
  endtask

  initial begin
    //          if_pc    v  br unc pc     tk tgt     ptk ptgt   e_pt e_ptgt  e_mis e_red
    // EX bubble with branch-looking inputs: no effect
    vecs[0]  = '{32'h100, 0, 1, 0, 32'h40, 1, 32'h80, 0, 32'h44, 0, 32'h104, 0, 32'h44};
    // first taken branch at 0x40 allocates ctr=2
    vecs[1]  = '{32'h40,  1, 1, 0, 32'h40, 1, 32'h80, 0, 32'h44, 0, 32'h44,  1, 32'h80};
    vecs[2]  = '{32'h40,  0, 0, 0, 32'h0,  0, 32'h0,  0, 32'h0,  1, 32'h80,  0, 32'h4};
    vecs[3]  = '{32'h40,  1, 1, 0, 32'h40, 1, 32'h80, 1, 32'h80, 1, 32'h80,  0, 32'h80};
    vecs[4]  = '{32'h40,  1, 1, 0, 32'h40, 1, 32'h80, 1, 32'h80, 1, 32'h80,  0, 32'h80};
    // hysteresis: 3 -> 2 still taken, 2 -> 1 not taken
    vecs[5]  = '{32'h40,  1, 1, 0, 32'h40, 0, 32'h80, 1, 32'h80, 1, 32'h80,  1, 32'h44};
    vecs[6]  = '{32'h40,  0, 0, 0, 32'h0,  0, 32'h0,  0, 32'h0,  1, 32'h80,  0, 32'h4};
    vecs[7]  = '{32'h40,  1, 1, 0, 32'h40, 0, 32'h80, 1, 32'h80, 1, 32'h80,  1, 32'h44};
    vecs[8]  = '{32'h40,  0, 0, 0, 32'h0,  0, 32'h0,  0, 32'h0,  0, 32'h44,  0, 32'h4};
    vecs[9]  = '{32'h40,  1, 1, 0, 32'h40, 1, 32'h80, 0, 32'h44, 0, 32'h44,  1, 32'h80};
    vecs[10] = '{32'h40,  1, 1, 0, 32'h40, 1, 32'h80, 1, 32'h80, 1, 32'h80,  0, 32'h80};
    // target change 0x80 -> 0x90
    vecs[11] = '{32'h40,  1, 1, 0, 32'h40, 1, 32'h90, 1, 32'h80, 1, 32'h80,  1, 32'h90};
    vecs[12] = '{32'h40,  0, 0, 0, 32'h0,  0, 32'h0,  0, 32'h0,  1, 32'h90,  0, 32'h4};
    // aliasing non-branch at 0x40 invalidates the entry
    vecs[13] = '{32'h40,  1, 0, 0, 32'h40, 0, 32'h0,  1, 32'h90, 1, 32'h90,  1, 32'h44};
    vecs[14] = '{32'h40,  0, 0, 0, 32'h0,  0, 32'h0,  0, 32'h0,  0, 32'h44,  0, 32'h4};
    // jump at 0x20 allocates strongly taken
    vecs[15] = '{32'h20,  1, 1, 1, 32'h20, 1, 32'h200,0, 32'h24, 0, 32'h24,  1, 32'h200};
    vecs[16] = '{32'h20,  1, 0, 0, 32'h30, 0, 32'h0,  0, 32'h34, 1, 32'h200, 0, 32'h34};
    // not-taken miss at 0x60 (same index as 0x20) changes nothing
    vecs[17] = '{32'h60,  1, 1, 0, 32'h60, 0, 32'h500,0, 32'h64, 0, 32'h64,  0, 32'h64};
    vecs[18] = '{32'h20,  0, 0, 0, 32'h0,  0, 32'h0,  0, 32'h0,  1, 32'h200, 0, 32'h4};
    // tag conflict: 0x40 then 0x80 share index 0
    vecs[19] = '{32'h40,  1, 1, 0, 32'h40, 1, 32'h80, 0, 32'h44, 0, 32'h44,  1, 32'h80};
    vecs[20] = '{32'h80,  1, 1, 0, 32'h80, 1, 32'h100,0, 32'h84, 0, 32'h84,  1, 32'h100};
    vecs[21] = '{32'h40,  0, 0, 0, 32'h0,  0, 32'h0,  0, 32'h0,  0, 32'h44,  0, 32'h4};
    vecs[22] = '{32'h80,  0, 0, 0, 32'h0,  0, 32'h0,  0, 32'h0,  1, 32'h100, 0, 32'h4};
    // aliasing on a tag miss leaves the resident entry alone
    vecs[23] = '{32'h80,  1, 0, 0, 32'h40, 0, 32'h0,  1, 32'h44, 1, 32'h100, 1, 32'h44};
    vecs[24] = '{32'h80,  0, 0, 0, 32'h0,  0, 32'h0,  0, 32'h0,  1, 32'h100, 0, 32'h4};

    rst_n = 1'b0;
    drive(vecs[0]);
    repeat (2) @(negedge clk);
    #1;
    check("reset_pred_taken", {31'd0, pred_taken}, 32'd0);
    check("reset_pred_target", pred_target, 32'h104);
    check("reset_stat_branches", {28'd0, stat_branches}, 32'd0);
    check("reset_stat_mispredicts", {28'd0, stat_mispredicts}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      $display("vec %0d: if_pc=0x%08h pt=%0d ptgt=0x%08h mis=%0d red=0x%08h",
               i, if_pc, pred_taken, pred_target, mispredict, redirect_pc);
      check($sformatf("v%0d_pred_taken", i), {31'd0, pred_taken}, {31'd0, vecs[i].e_pt});
      check($sformatf("v%0d_pred_target", i), pred_target, vecs[i].e_ptgt);
      check($sformatf("v%0d_mispredict", i), {31'd0, mispredict}, {31'd0, vecs[i].e_mis});
      check($sformatf("v%0d_redirect_pc", i), redirect_pc, vecs[i].e_red);
    end

    // statistics after the table: 12 resolved branches, 10 mispredicts
    @(negedge clk);
    drive('{32'h80, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0});
    #1;
    check("stat_branches_after_table", {28'd0, stat_branches}, 32'd12);
    check("stat_mispredicts_after_table", {28'd0, stat_mispredicts}, 32'd10);
    check("pre_reset_pred_taken", {31'd0, pred_taken}, 32'd1);

    // asynchronous reset in the middle of a cycle, with an update pending
    ex_valid = 1'b1; ex_is_branch = 1'b1; ex_pc = 32'h80; ex_taken = 1'b1;
    ex_target = 32'h700; ex_pred_taken = 1'b0; ex_pred_target = 32'h84;
    #1;
    rst_n = 1'b0;
    #1;
    $display("async reset: pt=%0d ptgt=0x%08h br=%0d mis=%0d",
             pred_taken, pred_target, stat_branches, stat_mispredicts);
    check("async_rst_pred_taken", {31'd0, pred_taken}, 32'd0);
    check("async_rst_pred_target", pred_target, 32'h84);
    check("async_rst_stat_branches", {28'd0, stat_branches}, 32'd0);
    check("async_rst_stat_mispredicts", {28'd0, stat_mispredicts}, 32'd0);
    @(negedge clk);
    ex_valid = 1'b0;
    #1;
    check("rst_idle_mispredict", {31'd0, mispredict}, 32'd0);
    check("rst_hold_pred_taken", {31'd0, pred_taken}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // saturation: 20 mispredicted taken branches into 4-bit counters
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if_pc = 32'h100; ex_valid = 1'b1; ex_is_branch = 1'b1; ex_uncond = 1'b0;
      ex_pc = 32'h100; ex_taken = 1'b1; ex_target = 32'h300;
      ex_pred_taken = 1'b0; ex_pred_target = 32'h104;
    end
    @(negedge clk);
    ex_valid = 1'b0;
    #1;
    $display("saturation: br=%0d mis=%0d pt=%0d ptgt=0x%08h",
             stat_branches, stat_mispredicts, pred_taken, pred_target);
    check("sat_stat_branches", {28'd0, stat_branches}, 32'd15);
    check("sat_stat_mispredicts", {28'd0, stat_mispredicts}, 32'd15);
    check("sat_pred_target", pred_target, 32'h300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
